// File: rtl/barcode_rx.sv
// Single-wire barcode receiver: measures the start-bit low time and samples
// eight MSB-first data bits at that offset after each falling edge.
module barcode_rx #(
   parameter int                TMR_W   = 22,
   parameter logic [TMR_W-1:0]  IDLE_TO = 22'h3F_FFFF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       BC,
   input  logic       clr_ID_vld,
   output logic [7:0] ID,
   output logic       ID_vld,
   output logic       rx_busy
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      WAIT_FALL,
      SAMPLE,
      WAIT_HIGH,
      DONE
   } state_t;

   state_t           state, state_nxt;
   logic             bc_s1, bc_s2, bc_s3;
   logic             lvl, fall;
   logic [TMR_W-1:0] tmr, tmr_nxt;
   logic [TMR_W-1:0] t_s, t_s_nxt;
   logic [7:0]       shift_reg, shift_nxt;
   logic [2:0]       bit_cnt, bit_cnt_nxt;
   logic             id_load;
   logic             tmr_sat;

   // Sync flops reset high so a released reset never fakes a falling edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bc_s1 <= 1'b1;
         bc_s2 <= 1'b1;
         bc_s3 <= 1'b1;
      end else begin
         bc_s1 <= BC;
         bc_s2 <= bc_s1;
         bc_s3 <= bc_s2;
      end
   end

   assign lvl     = bc_s2;
   assign fall    = bc_s3 & ~bc_s2;
   assign tmr_sat = (tmr == {TMR_W{1'b1}});
   assign rx_busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         tmr       <= '0;
         t_s       <= '0;
         shift_reg <= 8'h00;
         bit_cnt   <= 3'd0;
         ID        <= 8'h00;
         ID_vld    <= 1'b0;
      end else begin
         state     <= state_nxt;
         tmr       <= tmr_nxt;
         t_s       <= t_s_nxt;
         shift_reg <= shift_nxt;
         bit_cnt   <= bit_cnt_nxt;
         if (id_load) begin
            ID     <= shift_reg;
            ID_vld <= 1'b1;
         end else if (clr_ID_vld) begin
            ID_vld <= 1'b0;
         end
      end
   end

   // The timer saturates rather than wrapping so a huge start bit still
   // yields a usable (if clipped) sample offset.
   always_comb begin
      state_nxt   = state;
      tmr_nxt     = tmr;
      t_s_nxt     = t_s;
      shift_nxt   = shift_reg;
      bit_cnt_nxt = bit_cnt;
      id_load     = 1'b0;
      case (state)
         IDLE: begin
            if (fall) begin
               state_nxt   = START;
               tmr_nxt     = '0;
               bit_cnt_nxt = 3'd0;
            end
         end
         START: begin
            if (lvl) begin
               t_s_nxt   = tmr;
               tmr_nxt   = '0;
               state_nxt = WAIT_FALL;
            end else if (!tmr_sat) begin
               tmr_nxt = tmr + TMR_W'(1);
            end
         end
         WAIT_FALL: begin
            if (fall) begin
               tmr_nxt   = '0;
               state_nxt = SAMPLE;
            end else if (tmr >= IDLE_TO) begin
               state_nxt = IDLE;
            end else begin
               tmr_nxt = tmr + TMR_W'(1);
            end
         end
         SAMPLE: begin
            if (!tmr_sat) begin
               tmr_nxt = tmr + TMR_W'(1);
            end
            if (tmr == t_s) begin
               shift_nxt   = {shift_reg[6:0], lvl};
               bit_cnt_nxt = bit_cnt + 3'd1;
               state_nxt   = (bit_cnt == 3'd7) ? DONE : WAIT_HIGH;
            end
         end
         WAIT_HIGH: begin
            if (lvl) begin
               tmr_nxt   = '0;
               state_nxt = WAIT_FALL;
            end else if (tmr >= IDLE_TO) begin
               state_nxt = IDLE;
            end else if (!tmr_sat) begin
               tmr_nxt = tmr + TMR_W'(1);
            end
         end
         DONE: begin
            // Codes with either of the top two bits set are not station IDs.
            id_load   = (shift_reg[7:6] == 2'b00);
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_barcode_rx.sv
// Directed bench for barcode_rx: a transaction-level model predicts ID,
// ID_vld and rx_busy from frame timing, checked every cycle plus literals.
module tb_barcode_rx;

   localparam int          P   = 64;
   localparam int          LS  = 32;
   localparam int          L1  = 16;
   localparam int          L0  = 48;
   localparam logic [21:0] TO  = 22'd200;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       BC;
   logic       clr_ID_vld;
   logic [7:0] ID;
   logic       ID_vld;
   logic       rx_busy;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   bit started  = 1'b0;

   logic [7:0] exp_id   = 8'h00;
   logic       exp_vld  = 1'b0;
   logic       exp_busy = 1'b0;
   bit         busy_dc  = 1'b0;

   // kinds: 0 busy on, 1 clear, 2 valid done, 3 invalid done, 4 busy unknown, 5 busy off
   typedef struct {
      int         when;
      int         kind;
      logic [7:0] val;
   } ev_t;
   ev_t evq[$];

   barcode_rx #(.TMR_W(22), .IDLE_TO(TO)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .BC         (BC),
      .clr_ID_vld (clr_ID_vld),
      .ID         (ID),
      .ID_vld     (ID_vld),
      .rx_busy    (rx_busy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model state advances on each edge; clears apply before sets so a set wins.
   always @(posedge clk) begin
      ev_t keep[$];
      cyc++;
      started = 1'b1;
      if (rst_n === 1'b0) begin
         exp_id   = 8'h00;
         exp_vld  = 1'b0;
         exp_busy = 1'b0;
         busy_dc  = 1'b0;
         evq.delete();
      end else begin
         keep.delete();
         foreach (evq[i]) if (evq[i].when == cyc && evq[i].kind == 1) exp_vld = 1'b0;
         foreach (evq[i]) begin
            if (evq[i].when == cyc) begin
               case (evq[i].kind)
                  0: exp_busy = 1'b1;
                  2: begin exp_busy = 1'b0; exp_id = evq[i].val; exp_vld = 1'b1; end
                  3: exp_busy = 1'b0;
                  4: busy_dc = 1'b1;
                  5: begin busy_dc = 1'b0; exp_busy = 1'b0; end
                  default: ;
               endcase
            end else begin
               keep.push_back(evq[i]);
            end
         end
         evq = keep;
      end
   end

   always @(negedge clk) begin
      if (started) begin
         checkOutput("ID", ID, exp_id);
         checkOutput("ID_vld", {7'd0, ID_vld}, {7'd0, exp_vld});
         if (!busy_dc) checkOutput("rx_busy", {7'd0, rx_busy}, {7'd0, exp_busy});
      end
   end

   task automatic sendPulse(input int lowN, input int highN, input int clrStep);
      for (int i = 0; i < lowN + highN; i++) begin
         BC         = (i < lowN) ? 1'b0 : 1'b1;
         clr_ID_vld = (i == clrStep);
         tick();
      end
      clr_ID_vld = 1'b0;
   endtask

   // Sends a start bit and the first nbits of data; the ID lands LS+4 edges after the last fall.
   task automatic applyStimulus(input logic [7:0] data, input int nbits, input bit clrAtDone);
      int   f;
      logic b;
      evq.push_back('{cyc + 3, 0, 8'h00});
      sendPulse(LS, P - LS, -1);
      for (int i = 0; i < nbits; i++) begin
         b = data[7-i];
         if (i == 7) begin
            f = cyc;
            evq.push_back('{f + LS + 4, (data[7:6] == 2'b00) ? 2 : 3, data});
            if (clrAtDone) evq.push_back('{f + LS + 4, 1, 8'h00});
         end
         sendPulse(b ? L1 : L0, b ? P - L1 : P - L0, (i == 7 && clrAtDone) ? LS + 3 : -1);
      end
   endtask

   task automatic pulseClr();
      clr_ID_vld = 1'b1;
      evq.push_back('{cyc + 1, 1, 8'h00});
      tick();
      clr_ID_vld = 1'b0;
   endtask

   task automatic gap(input int n);
      BC = 1'b1;
      repeat (n) tick();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "[TB] timeout");
   end

   initial begin
      rst_n      = 1'b0;
      BC         = 1'b1;
      clr_ID_vld = 1'b0;
      repeat (4) begin
         BC = ~BC;
         tick();
      end
      checkOutput("rst_ID", ID, 8'h00);
      checkOutput("rst_vld", {7'd0, ID_vld}, 8'h00);
      checkOutput("rst_busy", {7'd0, rx_busy}, 8'h00);
      BC    = 1'b1;
      rst_n = 1'b1;
      gap(5);
      checkOutput("post_rst_ID", ID, 8'h00);
      checkOutput("post_rst_busy", {7'd0, rx_busy}, 8'h00);

      applyStimulus(8'h01, 8, 1'b0);
      gap(20);
      checkOutput("nom_ID", ID, 8'h01);
      checkOutput("nom_vld", {7'd0, ID_vld}, 8'h01);
      checkOutput("nom_busy", {7'd0, rx_busy}, 8'h00);

      applyStimulus(8'h02, 8, 1'b0);
      gap(10);
      checkOutput("b2b_ID1", ID, 8'h02);
      pulseClr();
      tick();
      checkOutput("b2b_clr_vld", {7'd0, ID_vld}, 8'h00);
      checkOutput("b2b_clr_ID", ID, 8'h02);
      applyStimulus(8'h3F, 8, 1'b0);
      gap(10);
      checkOutput("b2b_ID2", ID, 8'h3F);
      checkOutput("b2b_vld2", {7'd0, ID_vld}, 8'h01);

      applyStimulus(8'h01, 8, 1'b0);
      gap(10);
      applyStimulus(8'hC5, 8, 1'b0);
      gap(10);
      checkOutput("inv_ID", ID, 8'h01);
      checkOutput("inv_vld", {7'd0, ID_vld}, 8'h01);
      checkOutput("inv_busy", {7'd0, rx_busy}, 8'h00);

      applyStimulus(8'h15, 3, 1'b0);
      evq.push_back('{cyc + 1, 4, 8'h00});
      gap(int'(TO) + 40);
      evq.push_back('{cyc + 1, 5, 8'h00});
      tick();
      checkOutput("to_busy", {7'd0, rx_busy}, 8'h00);
      checkOutput("to_ID", ID, 8'h01);
      applyStimulus(8'h15, 8, 1'b0);
      gap(10);
      checkOutput("to_next_ID", ID, 8'h15);

      pulseClr();
      applyStimulus(8'h07, 8, 1'b1);
      gap(10);
      checkOutput("coll_clr_vld", {7'd0, ID_vld}, 8'h01);
      checkOutput("coll_clr_ID", ID, 8'h07);

      applyStimulus(8'h2A, 4, 1'b0);
      checkOutput("mid_busy", {7'd0, rx_busy}, 8'h01);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checkOutput("mid_rst_ID", ID, 8'h00);
      checkOutput("mid_rst_vld", {7'd0, ID_vld}, 8'h00);
      checkOutput("mid_rst_busy", {7'd0, rx_busy}, 8'h00);
      gap(20);
      applyStimulus(8'h2A, 8, 1'b0);
      gap(10);
      checkOutput("mid_next_ID", ID, 8'h2A);
      checkOutput("mid_next_vld", {7'd0, ID_vld}, 8'h01);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
